// File: rtl/kinase_activity_seq.sv
// Valve/pump sequencer for one kinase_activity chain: LOAD, CIRC, ELUTE separated by all-closed settles.
// Valve/pump lines are registered one clock behind the state; cmd_ready is high only in IDLE, busy commands are dropped.
module kinase_activity_seq #(
    parameter int CNT_W         = 16,
    parameter int PHASE_CYCLES  = 4,
    parameter int SETTLE_CYCLES = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_in_sel,
    input  logic [1:0]       cmd_out_sel,
    input  logic [CNT_W-1:0] cmd_load_len,
    input  logic [CNT_W-1:0] cmd_circ_len,
    input  logic [CNT_W-1:0] cmd_elute_len,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [2:0]       state,
    output logic [12:0]      ctrl_a,
    output logic [3:0]       ctrl_s,
    output logic [2:0]       pump_a,
    output logic [1:0]       pump_b
);

    localparam int CYC_MAX = (PHASE_CYCLES > SETTLE_CYCLES) ? PHASE_CYCLES : SETTLE_CYCLES;
    localparam int CYC_W   = $clog2(CYC_MAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_S1    = 3'd2,
        ST_CIRC  = 3'd3,
        ST_S2    = 3'd4,
        ST_ELUTE = 3'd5,
        ST_S3    = 3'd6
    } state_t;

    state_t           st;
    state_t           st_nxt;
    logic [1:0]       in_sel_q;
    logic [1:0]       out_sel_q;
    logic [CNT_W-1:0] load_len_q;
    logic [CNT_W-1:0] circ_len_q;
    logic [CNT_W-1:0] elute_len_q;
    logic [CYC_W-1:0] cyc_cnt;
    logic [CNT_W-1:0] step_cnt;
    logic [2:0]       pidx;

    logic             accept;
    logic             phase_tick;
    logic             settle_end;
    logic             load_end;
    logic             circ_end;
    logic             elute_end;

    logic [12:0]      ctrl_a_nxt;
    logic [3:0]       ctrl_s_nxt;
    logic [2:0]       pump_a_nxt;
    logic [1:0]       pump_b_nxt;

    assign cmd_ready = (st == ST_IDLE) & ~rst;
    assign busy      = (st != ST_IDLE);
    assign state     = st;
    assign accept    = cmd_valid & cmd_ready;

    assign phase_tick = (cyc_cnt == CYC_W'(PHASE_CYCLES - 1));
    assign settle_end = (cyc_cnt == CYC_W'(SETTLE_CYCLES - 1));
    assign load_end   = phase_tick && (step_cnt == load_len_q - CNT_W'(1));
    assign circ_end   = phase_tick && (step_cnt == circ_len_q - CNT_W'(1));
    assign elute_end  = (step_cnt == elute_len_q - CNT_W'(1));

    // Zero-length phases are skipped at the decision point, so their preceding settle still runs.
    always_comb begin
        st_nxt = st;
        case (st)
            ST_IDLE: begin
                if (accept && cmd_in_sel != 2'd3)
                    st_nxt = (cmd_load_len != '0) ? ST_LOAD : ST_S1;
            end
            ST_LOAD:  if (load_end)   st_nxt = ST_S1;
            ST_S1:    if (settle_end) st_nxt = (circ_len_q != '0) ? ST_CIRC : ST_S2;
            ST_CIRC:  if (circ_end)   st_nxt = ST_S2;
            ST_S2:    if (settle_end) st_nxt = (elute_len_q != '0) ? ST_ELUTE : ST_S3;
            ST_ELUTE: if (elute_end)  st_nxt = ST_S3;
            ST_S3:    if (settle_end) st_nxt = ST_IDLE;
            default:                  st_nxt = ST_IDLE;
        endcase
        if (abort && st != ST_IDLE && st != ST_S3)
            st_nxt = ST_S3;
    end

    // Air bit 1 closes a line; everything not opened by the current phase stays closed.
    always_comb begin
        ctrl_a_nxt = '1;
        ctrl_s_nxt = '1;
        pump_a_nxt = '1;
        pump_b_nxt = '1;
        case (st)
            ST_LOAD: begin
                ctrl_a_nxt[4'd1 + {2'b00, in_sel_q}] = 1'b0;
                ctrl_a_nxt[4]  = 1'b0;
                ctrl_a_nxt[6]  = 1'b0;
                ctrl_s_nxt[1]  = 1'b0;
                pump_b_nxt     = step_cnt[0] ? 2'b01 : 2'b10;
            end
            ST_CIRC: begin
                ctrl_a_nxt[5]  = 1'b0;
                ctrl_a_nxt[7]  = 1'b0;
                ctrl_a_nxt[9]  = 1'b0;
                case (pidx)
                    3'd0:    pump_a_nxt = 3'b101;
                    3'd1:    pump_a_nxt = 3'b100;
                    3'd2:    pump_a_nxt = 3'b110;
                    3'd3:    pump_a_nxt = 3'b010;
                    3'd4:    pump_a_nxt = 3'b011;
                    default: pump_a_nxt = 3'b001;
                endcase
            end
            ST_ELUTE: begin
                ctrl_a_nxt[10] = 1'b0;
                case (out_sel_q)
                    2'd0:    ctrl_a_nxt[12] = 1'b0;
                    2'd1:    ctrl_a_nxt[8]  = 1'b0;
                    2'd2:    ctrl_a_nxt[11] = 1'b0;
                    default: ctrl_a_nxt[0]  = 1'b0;
                endcase
                ctrl_s_nxt[3]  = 1'b0;
                ctrl_s_nxt[0]  = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st          <= ST_IDLE;
            in_sel_q    <= '0;
            out_sel_q   <= '0;
            load_len_q  <= '0;
            circ_len_q  <= '0;
            elute_len_q <= '0;
            cyc_cnt     <= '0;
            step_cnt    <= '0;
            pidx        <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
            ctrl_a      <= 13'h1FFF;
            ctrl_s      <= 4'hF;
            pump_a      <= 3'b111;
            pump_b      <= 2'b11;
        end else begin
            st     <= st_nxt;
            done   <= (st == ST_S3) && settle_end;
            err    <= accept && (cmd_in_sel == 2'd3);
            ctrl_a <= ctrl_a_nxt;
            ctrl_s <= ctrl_s_nxt;
            pump_a <= pump_a_nxt;
            pump_b <= pump_b_nxt;

            if (accept) begin
                in_sel_q    <= cmd_in_sel;
                out_sel_q   <= cmd_out_sel;
                load_len_q  <= cmd_load_len;
                circ_len_q  <= cmd_circ_len;
                elute_len_q <= cmd_elute_len;
            end

            // Every state change restarts the cycle, step and pump-phase counters.
            if (st_nxt != st) begin
                cyc_cnt  <= '0;
                step_cnt <= '0;
                pidx     <= '0;
            end else begin
                case (st)
                    ST_LOAD, ST_CIRC: begin
                        if (phase_tick) begin
                            cyc_cnt  <= '0;
                            step_cnt <= step_cnt + CNT_W'(1);
                            pidx     <= (pidx == 3'd5) ? 3'd0 : pidx + 3'd1;
                        end else begin
                            cyc_cnt  <= cyc_cnt + CYC_W'(1);
                        end
                    end
                    ST_ELUTE:            step_cnt <= step_cnt + CNT_W'(1);
                    ST_S1, ST_S2, ST_S3: cyc_cnt  <= cyc_cnt + CYC_W'(1);
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_kinase_activity_seq.sv
// Bench for kinase_activity_seq: per-cycle comparison against a phase-timeline model built from command fields.
module tb_kinase_activity_seq;

    localparam int CNT_W = 16;
    localparam int PH    = 4;
    localparam int SE    = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_in_sel = '0;
    logic [1:0]       cmd_out_sel = '0;
    logic [CNT_W-1:0] cmd_load_len = '0;
    logic [CNT_W-1:0] cmd_circ_len = '0;
    logic [CNT_W-1:0] cmd_elute_len = '0;
    logic             abort = 1'b0;
    logic             busy;
    logic             done;
    logic             err;
    logic [2:0]       state;
    logic [12:0]      ctrl_a;
    logic [3:0]       ctrl_s;
    logic [2:0]       pump_a;
    logic [1:0]       pump_b;

    int n_checks = 0;
    int n_fail   = 0;

    int q_st[$];
    int q_k[$];

    kinase_activity_seq #(.CNT_W(CNT_W), .PHASE_CYCLES(PH), .SETTLE_CYCLES(SE)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_in_sel(cmd_in_sel), .cmd_out_sel(cmd_out_sel),
        .cmd_load_len(cmd_load_len), .cmd_circ_len(cmd_circ_len), .cmd_elute_len(cmd_elute_len),
        .abort(abort), .busy(busy), .done(done), .err(err), .state(state),
        .ctrl_a(ctrl_a), .ctrl_s(ctrl_s), .pump_a(pump_a), .pump_b(pump_b)
    );

    always #5 clk = ~clk;

    localparam logic [21:0] CLOSED = {13'h1FFF, 4'hF, 3'b111, 2'b11};

    // Lines for cycle k of a phase: pump steps are k/PH, sequence position wraps every six steps.
    function automatic logic [21:0] exp_lines(int st, int k, int isel, int osel);
        logic [12:0] a;
        logic [3:0]  s;
        logic [2:0]  pa;
        logic [1:0]  pb;
        int          oidx;
        a = '1; s = '1; pa = '1; pb = '1;
        oidx = 0;
        case (st)
            1: begin
                a[4'(1 + isel)] = 1'b0; a[4] = 1'b0; a[6] = 1'b0; s[1] = 1'b0;
                pb = (((k / PH) % 2) == 1) ? 2'b01 : 2'b10;
            end
            3: begin
                a[5] = 1'b0; a[7] = 1'b0; a[9] = 1'b0;
                case ((k / PH) % 6)
                    0: pa = 3'b101;
                    1: pa = 3'b100;
                    2: pa = 3'b110;
                    3: pa = 3'b010;
                    4: pa = 3'b011;
                    default: pa = 3'b001;
                endcase
            end
            5: begin
                oidx = (osel == 0) ? 12 : (osel == 1) ? 8 : (osel == 2) ? 11 : 0;
                a[10] = 1'b0; a[4'(oidx)] = 1'b0; s[3] = 1'b0; s[0] = 1'b0;
            end
            default: ;
        endcase
        return {a, s, pa, pb};
    endfunction

    task automatic build(input int ll, input int cl, input int el, input int abort_at);
        q_st.delete();
        q_k.delete();
        for (int i = 0; i < ll * PH; i++) begin q_st.push_back(1); q_k.push_back(i); end
        for (int i = 0; i < SE; i++)      begin q_st.push_back(2); q_k.push_back(i); end
        for (int i = 0; i < cl * PH; i++) begin q_st.push_back(3); q_k.push_back(i); end
        for (int i = 0; i < SE; i++)      begin q_st.push_back(4); q_k.push_back(i); end
        for (int i = 0; i < el; i++)      begin q_st.push_back(5); q_k.push_back(i); end
        for (int i = 0; i < SE; i++)      begin q_st.push_back(6); q_k.push_back(i); end
        if (abort_at >= 0 && abort_at < q_st.size() && q_st[abort_at] != 6) begin
            while (q_st.size() > abort_at + 1) begin
                void'(q_st.pop_back());
                void'(q_k.pop_back());
            end
            for (int i = 0; i < SE; i++) begin q_st.push_back(6); q_k.push_back(i); end
        end
    endtask

    // Called at a negedge; leaves at the negedge after the run has returned to IDLE for one cycle.
    task automatic run_cmd(input string name, input int isel, input int osel, input int ll,
                           input int cl, input int el, input int abort_at, input bit noise);
        int          n;
        int          es;
        logic [21:0] el_exp;
        logic [28:0] exp_v;
        logic [28:0] obs_v;
        build(ll, cl, el, abort_at);
        n = q_st.size();
        cmd_valid     = 1'b1;
        cmd_in_sel    = 2'(isel);
        cmd_out_sel   = 2'(osel);
        cmd_load_len  = CNT_W'(ll);
        cmd_circ_len  = CNT_W'(cl);
        cmd_elute_len = CNT_W'(el);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int t = 0; t <= n + 1; t++) begin
            es = (t < n) ? q_st[t] : 0;
            if (t == 0 || t - 1 >= n) el_exp = CLOSED;
            else el_exp = exp_lines(q_st[t-1], q_k[t-1], isel, osel);
            exp_v = {3'(es), (t < n), (t == n), 1'b0, (es == 0), el_exp};
            obs_v = {state, busy, done, err, cmd_ready, ctrl_a, ctrl_s, pump_a, pump_b};
            n_checks++;
            if (obs_v !== exp_v) begin
                n_fail++;
                $display("FAIL %s cycle %0d: got st=%0d busy=%b done=%b err=%b rdy=%b a=%h s=%h pa=%b pb=%b, want %h",
                         name, t, state, busy, done, err, cmd_ready, ctrl_a, ctrl_s, pump_a, pump_b, exp_v);
            end
            abort = (t == abort_at) || (t == n);
            if (noise && t < n) begin
                cmd_valid     = 1'($urandom_range(0, 1));
                cmd_in_sel    = 2'($urandom_range(0, 3));
                cmd_out_sel   = 2'($urandom_range(0, 3));
                cmd_load_len  = CNT_W'($urandom_range(0, 5));
                cmd_circ_len  = CNT_W'($urandom_range(0, 5));
                cmd_elute_len = CNT_W'($urandom_range(0, 5));
            end else begin
                cmd_valid = 1'b0;
            end
            @(negedge clk);
        end
        abort     = 1'b0;
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({state, busy, done, err, cmd_ready, ctrl_a, ctrl_s, pump_a, pump_b} !== {3'd0, 4'b0000, CLOSED}) begin
            n_fail++;
            $display("FAIL reset_hold: got st=%0d busy=%b done=%b err=%b rdy=%b a=%h s=%h pa=%b pb=%b",
                     state, busy, done, err, cmd_ready, ctrl_a, ctrl_s, pump_a, pump_b);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if ({cmd_ready, busy, ctrl_a, ctrl_s, pump_a, pump_b} !== {2'b10, CLOSED}) begin
            n_fail++;
            $display("FAIL reset_release: got rdy=%b busy=%b a=%h s=%h pa=%b pb=%b, want rdy=1 busy=0 closed",
                     cmd_ready, busy, ctrl_a, ctrl_s, pump_a, pump_b);
        end
        @(negedge clk);
    endtask

    task automatic test_happy();
        run_cmd("happy", 1, 2, 2, 3, 5, -1, 1'b0);
    endtask

    task automatic test_reject();
        cmd_valid = 1'b1; cmd_in_sel = 2'd3; cmd_out_sel = 2'd1;
        cmd_load_len = 16'd2; cmd_circ_len = 16'd2; cmd_elute_len = 16'd2;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        n_checks++;
        if ({err, state, busy, done, cmd_ready, ctrl_a, ctrl_s, pump_a, pump_b} !== {1'b1, 3'd0, 3'b001, CLOSED}) begin
            n_fail++;
            $display("FAIL reject_pulse: got err=%b st=%0d busy=%b done=%b rdy=%b a=%h, want err=1 idle closed",
                     err, state, busy, done, cmd_ready, ctrl_a);
        end
        @(negedge clk);
        n_checks++;
        if ({err, state, busy} !== 5'b0) begin
            n_fail++;
            $display("FAIL reject_after: got err=%b st=%0d busy=%b, want 0 0 0", err, state, busy);
        end
    endtask

    task automatic test_zero_lengths();
        run_cmd("zero_circ", 0, 0, 2, 0, 3, -1, 1'b0);
        run_cmd("zero_all", 2, 3, 0, 0, 0, -1, 1'b0);
        run_cmd("zero_load", 0, 1, 0, 1, 1, -1, 1'b0);
    endtask

    task automatic test_abort();
        run_cmd("abort_circ", 1, 2, 2, 3, 5, 2 * SE + 2 * PH + 1, 1'b0);
        run_cmd("abort_s3", 2, 0, 1, 1, 2, 8 + 8 + 4 + 8 + 2 + 3, 1'b0);
        run_cmd("abort_load", 0, 3, 3, 2, 2, 0, 1'b0);
    endtask

    task automatic test_rst_mid_run();
        build(2, 3, 5, -1);
        cmd_valid = 1'b1; cmd_in_sel = 2'd1; cmd_out_sel = 2'd2;
        cmd_load_len = 16'd2; cmd_circ_len = 16'd3; cmd_elute_len = 16'd5;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (38) @(negedge clk);
        n_checks++;
        if (state !== 3'(q_st[38])) begin
            n_fail++;
            $display("FAIL rst_mid_state: got st=%0d, want %0d", state, q_st[38]);
        end
        rst = 1'b1;
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({state, busy, done, err, cmd_ready, ctrl_a, ctrl_s, pump_a, pump_b} !== {3'd0, 4'b0000, CLOSED}) begin
            n_fail++;
            $display("FAIL rst_mid_values: got st=%0d busy=%b done=%b rdy=%b a=%h s=%h pa=%b pb=%b",
                     state, busy, done, cmd_ready, ctrl_a, ctrl_s, pump_a, pump_b);
        end
        rst = 1'b0;
        cmd_valid = 1'b0;
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            n_checks++;
            if ({done, busy, state} !== 5'b0) begin
                n_fail++;
                $display("FAIL rst_mid_quiet cycle %0d: got done=%b busy=%b st=%0d, want 0", t, done, busy, state);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 8; r++) begin
            run_cmd("random", int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 8)), int'($urandom_range(0, 6)),
                    ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 70)) : -1, 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_happy();
        test_reject();
        test_zero_lengths();
        test_abort();
        test_rst_mid_run();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
